// File: rtl/mem_sram_stage_if.sv
// mem_sram_stage_if: EXE->MEM controls, MEM/WB register outputs and the
// 16-bit external SRAM pins of the memory stage, bundled as one bus.
// slave  = the memory stage itself
// master = the surrounding pipeline / SRAM device side
interface mem_sram_stage_if;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DEST_W  = 4;
  localparam int unsigned SADDR_W = 18;
  localparam int unsigned SDATA_W = 16;

  // EXE stage register side
  logic               WB_EN_IN;
  logic               MEM_R_EN_IN;
  logic               MEM_W_EN_IN;
  logic [DATA_W-1:0]  ALU_result_IN;
  logic [DATA_W-1:0]  ST_val_IN;
  logic [DEST_W-1:0]  Dest_IN;

  // pipeline freeze
  logic               ready;

  // MEM/WB register
  logic               WB_EN;
  logic               MEM_R_EN;
  logic [DATA_W-1:0]  ALU_result;
  logic [DATA_W-1:0]  MEM_result;
  logic [DEST_W-1:0]  Dest;

  // external SRAM
  logic [SADDR_W-1:0] SRAM_ADDR;
  logic [SDATA_W-1:0] SRAM_DQ_OUT;
  logic [SDATA_W-1:0] SRAM_DQ_IN;
  logic               SRAM_DQ_OE;
  logic               SRAM_WE_N;

  modport slave (
    input  WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, ALU_result_IN, ST_val_IN, Dest_IN,
    input  SRAM_DQ_IN,
    output ready,
    output WB_EN, MEM_R_EN, ALU_result, MEM_result, Dest,
    output SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_WE_N
  );

  modport master (
    output WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, ALU_result_IN, ST_val_IN, Dest_IN,
    output SRAM_DQ_IN,
    input  ready,
    input  WB_EN, MEM_R_EN, ALU_result, MEM_result, Dest,
    input  SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_WE_N
  );
endinterface

// File: rtl/mem_sram_stage.sv
// mem_sram_stage: pipeline MEM stage driving a 16-bit external SRAM.
// Each 32-bit access is split into a low half-word phase (LO) followed by a
// high half-word phase (HI); the pipeline is frozen (ready=0) until DONE.
// Optional feature macro SRAM_WAIT_EN: when defined, every LO/HI phase is
// stretched to WAIT_CYCLES+1 cycles by a per-phase wait counter; when
// undefined each phase is one cycle and WAIT_CYCLES has no effect.
module mem_sram_stage #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_sram_stage_if.slave bus
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned DEST_W  = 4;
  localparam int unsigned WORD_W  = 17;
  localparam int unsigned SADDR_W = 18;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state_q;
  logic [1:0]         state_d;

  logic               mem_req_c;
  logic               is_write_c;
  logic               is_read_c;
  logic               in_phase_c;
  logic               phase_last_c;
  logic               ready_c;
  logic [WORD_W-1:0]  word_c;

  logic [SADDR_W-1:0] sram_addr_c;
  logic [HALF_W-1:0]  sram_dq_out_c;
  logic               sram_dq_oe_c;
  logic               sram_we_n_c;

  logic [DATA_W-1:0]  rd_buf_q;

  logic               wb_en_q;
  logic               mem_r_en_q;
  logic [DATA_W-1:0]  alu_result_q;
  logic [DATA_W-1:0]  mem_result_q;
  logic [DEST_W-1:0]  dest_q;

  // request decode; a simultaneous read+write is treated as a write
  assign mem_req_c  = bus.MEM_W_EN_IN | bus.MEM_R_EN_IN;
  assign is_write_c = bus.MEM_W_EN_IN;
  assign is_read_c  = bus.MEM_R_EN_IN & ~bus.MEM_W_EN_IN;
  assign in_phase_c = (state_q == LO) || (state_q == HI);

  // SRAM word index relative to the mapped base, wrapping within the 17-bit space
  assign word_c = WORD_W'((bus.ALU_result_IN - DATA_W'(ADDR_BASE)) >> 2);

  // stage accepts when finishing an access or when idle with nothing to do
  assign ready_c = (state_q == DONE) || ((state_q == IDLE) && !mem_req_c);

`ifdef SRAM_WAIT_EN
  localparam int unsigned WCNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  logic [WCNT_W-1:0] wcnt_q;

  assign phase_last_c = (DATA_W'(wcnt_q) == DATA_W'(WAIT_CYCLES));

  // cycles spent in the current LO/HI phase; cleared on every state change
  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt_q <= '0;
    end else if (state_q != state_d) begin
      wcnt_q <= '0;
    end else if (in_phase_c) begin
      wcnt_q <= wcnt_q + WCNT_W'(1);
    end else begin
      wcnt_q <= '0;
    end
  end
`else
  assign phase_last_c = 1'b1;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: IDLE -> LO -> HI -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_req_c)    state_d = LO;
      LO:      if (phase_last_c) state_d = HI;
      HI:      if (phase_last_c) state_d = DONE;
      DONE:                      state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // SRAM pin drive: bus is only active during LO/HI, write pins only for writes
  always_comb begin
    sram_addr_c   = '0;
    sram_dq_out_c = '0;
    sram_dq_oe_c  = 1'b0;
    sram_we_n_c   = 1'b1;
    if (in_phase_c) begin
      sram_addr_c = {word_c, (state_q == HI)};
      if (is_write_c) begin
        sram_dq_oe_c  = 1'b1;
        sram_we_n_c   = 1'b0;
        sram_dq_out_c = (state_q == HI) ? bus.ST_val_IN[DATA_W-1:HALF_W]
                                        : bus.ST_val_IN[HALF_W-1:0];
      end
    end
  end

  // read buffer: capture each half-word on the last cycle of its phase
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_buf_q <= '0;
    end else if (is_read_c && phase_last_c) begin
      if (state_q == LO) begin
        rd_buf_q[HALF_W-1:0] <= bus.SRAM_DQ_IN;
      end else if (state_q == HI) begin
        rd_buf_q[DATA_W-1:HALF_W] <= bus.SRAM_DQ_IN;
      end
    end
  end

  // MEM/WB register: loads every cycle, bubble while the stage is stalled
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      alu_result_q <= '0;
      mem_result_q <= '0;
      dest_q       <= '0;
    end else if (ready_c) begin
      wb_en_q      <= bus.WB_EN_IN;
      mem_r_en_q   <= is_read_c;
      alu_result_q <= bus.ALU_result_IN;
      mem_result_q <= rd_buf_q;
      dest_q       <= bus.Dest_IN;
    end else begin
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
    end
  end

  // port hookup
  assign bus.ready       = ready_c;
  assign bus.WB_EN       = wb_en_q;
  assign bus.MEM_R_EN    = mem_r_en_q;
  assign bus.ALU_result  = alu_result_q;
  assign bus.MEM_result  = mem_result_q;
  assign bus.Dest        = dest_q;
  assign bus.SRAM_ADDR   = sram_addr_c;
  assign bus.SRAM_DQ_OUT = sram_dq_out_c;
  assign bus.SRAM_DQ_OE  = sram_dq_oe_c;
  assign bus.SRAM_WE_N   = sram_we_n_c;

endmodule

// File: doc/mem_sram_stage.md
MEM_SRAM_STAGE -- requirements
Module: mem_sram_stage

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 1024, byte address mapped to SRAM word 0.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra cycles per half-word access; used only with SRAM_WAIT_EN.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN  in  1 each  controls from the EXE stage register.
REQ-006 SHALL have ports ALU_result_IN  in  32 (address/ALU value), ST_val_IN  in  32 (store data), Dest_IN  in  4.
REQ-007 SHALL have port ready  out  1  high = stage accepts; low = freeze all upstream stage registers and PC.
REQ-008 SHALL have MEM/WB outputs WB_EN (1), MEM_R_EN (1), ALU_result (32), MEM_result (32), Dest (4).
REQ-009 SHALL have SRAM ports SRAM_ADDR out 18, SRAM_DQ_OUT out 16, SRAM_DQ_IN in 16, SRAM_DQ_OE out 1, SRAM_WE_N out 1 (active low).

Function
REQ-010 SHALL implement FSM states IDLE, LO, HI, DONE.
REQ-011 IDLE: MEM_W_EN_IN or MEM_R_EN_IN high -> LO; else stay IDLE.
REQ-012 LO -> HI and HI -> DONE after phase length (1 cycle; WAIT_CYCLES+1 with SRAM_WAIT_EN); DONE -> IDLE unconditionally.
REQ-013 ready SHALL be combinational: 1 in DONE, 1 in IDLE with no memory request, else 0.
REQ-014 Word address SHALL be (ALU_result_IN - ADDR_BASE) >> 2, truncated to 17 bits, wrapping modulo 2^17; SRAM_ADDR = {word[16:0], 0} in LO, {word[16:0], 1} in HI, 0 otherwise.
REQ-015 Write: SRAM_DQ_OE=1 and SRAM_WE_N=0 in every LO/HI cycle; SRAM_DQ_OUT = ST_val_IN[15:0] in LO, [31:16] in HI.
REQ-016 Read: SRAM_DQ_OE=0, SRAM_WE_N=1; SRAM_DQ_IN captured in last cycle of LO into low half, last cycle of HI into high half.
REQ-017 Outside LO/HI: SRAM_WE_N=1, SRAM_DQ_OE=0, SRAM_DQ_OUT=0.
REQ-018 MEM_R_EN_IN and MEM_W_EN_IN both high SHALL be handled as a write; MEM_R_EN output forced 0.
REQ-019 MEM/WB register SHALL load every cycle: when ready=1 it takes WB_EN_IN, MEM_R_EN_IN, ALU_result_IN, assembled read word, Dest_IN; when ready=0 it loads WB_EN=0, MEM_R_EN=0 (bubble), other fields don't-care but held.
REQ-020 Non-memory instruction latency: 1 cycle, no stall; memory op stall = 1 + 2*(phase length) cycles.
REQ-021 Upstream holds all *_IN stable while ready=0; block SHALL NOT re-sample a new request until IDLE.

Reset
REQ-022 rst low at a clock edge SHALL force state IDLE, read buffer 0, WB_EN=0, MEM_R_EN=0, ALU_result=0, MEM_result=0, Dest=0.
REQ-023 Reset mid-access SHALL abort immediately: next cycle SRAM_WE_N=1, SRAM_DQ_OE=0, no partial write-back issued.

Configuration
REQ-024 Macro SRAM_WAIT_EN defined: each LO/HI phase lasts WAIT_CYCLES+1 cycles via a wait counter reset on phase entry.
REQ-025 SRAM_WAIT_EN undefined: each phase lasts exactly 1 cycle; WAIT_CYCLES ignored, no counter built.

Verification
REQ-026 Non-mem op WB_EN_IN=1, ALU_result_IN=0x55, Dest_IN=3 -> ready stays 1; next cycle WB_EN=1, ALU_result=0x55, Dest=3.
REQ-027 Store ST_val_IN=0xDEADBEEF at 1032, no SRAM_WAIT_EN -> ready low 3 cycles; SRAM_ADDR 4 then 5, DQ_OUT 0xBEEF then 0xDEAD, WE_N low 2 cycles.
REQ-028 Load from 1028, SRAM model returns 0x1234 (addr 2), 0xABCD (addr 3) -> MEM_result=0xABCD1234, MEM_R_EN=1, after DONE.
REQ-029 SRAM_WAIT_EN, WAIT_CYCLES=2, load -> ready low 7 cycles; each address held 3 cycles; WB_EN=0 throughout stall.
REQ-030 rst low during HI of a store -> next cycle IDLE, WE_N=1, DQ_OE=0, WB_EN=0; next request starts at LO.
REQ-031 MEM_R_EN_IN=MEM_W_EN_IN=1 -> write cycles on SRAM, MEM_R_EN output 0.
